// File: rtl/imem_pipelined.sv
// rtl/imem_pipelined.sv - loadable instruction memory with stallable, configurable-latency read pipeline
module imem_pipelined #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 12,
    parameter int                    DEPTH        = 4096,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  stall,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid,
    output logic                  oob,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    // Contents start zeroed and are deliberately untouched by reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic                  stage_valid [READ_LATENCY];
    logic                  stage_oob   [READ_LATENCY];
    logic [DATA_WIDTH-1:0] stage_data  [READ_LATENCY];

    logic accept;
    logic rd_in_range;
    logic wr_in_range;

    assign accept      = rd_en && !stall;
    assign rd_in_range = {1'b0, address} < DEPTH_W;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;

    always_ff @(posedge clock) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Reading mem here sees the pre-edge contents, giving read-first behaviour.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_valid[i] <= 1'b0;
                stage_oob[i]   <= 1'b0;
                stage_data[i]  <= NOP_WORD;
            end
        end else if (!stall) begin
            stage_valid[0] <= accept;
            stage_oob[0]   <= accept && !rd_in_range;
            if (accept) begin
                stage_data[0] <= rd_in_range ? mem[address[IDX_W-1:0]] : NOP_WORD;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_oob[i]   <= stage_oob[i-1];
                stage_data[i]  <= stage_data[i-1];
            end
        end
    end

    assign q       = stage_data[READ_LATENCY-1];
    assign q_valid = stage_valid[READ_LATENCY-1];
    assign oob     = stage_oob[READ_LATENCY-1];

endmodule

// File: tb/tb_imem_pipelined.sv
// tb/tb_imem_pipelined.sv - directed checks of imem_pipelined at read latencies 2 and 3
module tb_imem_pipelined;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        rd_en;
    logic [11:0] address;
    logic        stall;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;

    logic [31:0] q2, q3;
    logic        qv2, qv3, oob2, oob3;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    imem_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(1024), .READ_LATENCY(2), .NOP_WORD(NOP)
    ) dut2 (
        .clock(clock), .reset(reset), .rd_en(rd_en), .address(address), .stall(stall),
        .q(q2), .q_valid(qv2), .oob(oob2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    imem_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(1024), .READ_LATENCY(3), .NOP_WORD(NOP)
    ) dut3 (
        .clock(clock), .reset(reset), .rd_en(rd_en), .address(address), .stall(stall),
        .q(q3), .q_valid(qv3), .oob(oob3),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        rd_en = 1'b0;
        stall = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_word(input logic [11:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_en = 1'b0; stall = 1'b0; wr_en = 1'b0;
        address = '0; wr_addr = '0; wr_data = '0;
        step();
        step();
        tests_run++;
        if (q2 !== NOP || qv2 !== 1'b0 || oob2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_l2 got q=%h v=%b oob=%b exp q=%h v=0 oob=0", q2, qv2, oob2, NOP);
        end
        tests_run++;
        if (q3 !== NOP || qv3 !== 1'b0 || oob3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_l3 got q=%h v=%b oob=%b exp q=%h v=0 oob=0", q3, qv3, oob3, NOP);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
        for (int i = 0; i < 4; i++) write_word(12'(i), words[i]);
        for (int c = 0; c < 7; c++) begin
            rd_en   = (c < 4);
            address = 12'(c);
            step();
            tests_run++;
            if (qv2 !== (c >= 1 && c <= 4) || oob2 !== 1'b0 ||
                (c >= 1 && c <= 4 && q2 !== words[c-1])) begin
                tests_failed++;
                $display("FAIL b2b_l2 c=%0d got v=%b q=%h oob=%b", c, qv2, q2, oob2);
            end
            tests_run++;
            if (qv3 !== (c >= 2 && c <= 5) || oob3 !== 1'b0 ||
                (c >= 2 && c <= 5 && q3 !== words[c-2])) begin
                tests_failed++;
                $display("FAIL b2b_l3 c=%0d got v=%b q=%h oob=%b", c, qv3, q3, oob3);
            end
        end
        idle(3);
    endtask

    task automatic test_stall();
        // Per cycle: rd_en, address, stall, then expected valid/data for both latencies.
        logic        in_rd   [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        logic [11:0] in_ad   [10] = '{0, 1, 2, 2, 2, 2, 3, 0, 0, 0};
        logic        in_st   [10] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
        logic        e2_v    [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        logic [31:0] e2_q    [10] = '{0, 32'h11, 32'h11, 32'h11, 32'h11, 32'h22, 32'h33, 32'h44, 32'h44, 32'h44};
        logic        e3_v    [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
        logic [31:0] e3_q    [10] = '{0, 0, 0, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h44};
        for (int c = 0; c < 10; c++) begin
            rd_en   = in_rd[c];
            address = in_ad[c];
            stall   = in_st[c];
            step();
            tests_run++;
            if (qv2 !== e2_v[c] || (c >= 1 && q2 !== e2_q[c])) begin
                tests_failed++;
                $display("FAIL stall_l2 c=%0d got v=%b q=%h exp v=%b q=%h", c, qv2, q2, e2_v[c], e2_q[c]);
            end
            tests_run++;
            if (qv3 !== e3_v[c] || (c >= 5 && q3 !== e3_q[c])) begin
                tests_failed++;
                $display("FAIL stall_l3 c=%0d got v=%b q=%h exp v=%b q=%h", c, qv3, q3, e3_v[c], e3_q[c]);
            end
        end
        idle(3);
    endtask

    task automatic test_read_during_write();
        wr_en = 1'b1; wr_addr = 12'd5; wr_data = 32'hDEAD;
        rd_en = 1'b1; address = 12'd5;
        step();
        wr_en = 1'b0;
        step();
        tests_run++;
        if (qv2 !== 1'b1 || q2 !== 32'h0) begin
            tests_failed++;
            $display("FAIL rdw_old_l2 got v=%b q=%h exp v=1 q=00000000", qv2, q2);
        end
        rd_en = 1'b0;
        step();
        tests_run++;
        if (qv2 !== 1'b1 || q2 !== 32'hDEAD) begin
            tests_failed++;
            $display("FAIL rdw_new_l2 got v=%b q=%h exp v=1 q=0000dead", qv2, q2);
        end
        tests_run++;
        if (qv3 !== 1'b1 || q3 !== 32'h0) begin
            tests_failed++;
            $display("FAIL rdw_old_l3 got v=%b q=%h exp v=1 q=00000000", qv3, q3);
        end
        step();
        tests_run++;
        if (qv3 !== 1'b1 || q3 !== 32'hDEAD) begin
            tests_failed++;
            $display("FAIL rdw_new_l3 got v=%b q=%h exp v=1 q=0000dead", qv3, q3);
        end
        idle(3);
    endtask

    task automatic test_oob();
        rd_en = 1'b1; address = 12'h400;
        step();
        rd_en = 1'b0;
        step();
        tests_run++;
        if (qv2 !== 1'b1 || oob2 !== 1'b1 || q2 !== NOP) begin
            tests_failed++;
            $display("FAIL oob_l2 got v=%b oob=%b q=%h exp v=1 oob=1 q=%h", qv2, oob2, q2, NOP);
        end
        step();
        tests_run++;
        if (qv3 !== 1'b1 || oob3 !== 1'b1 || q3 !== NOP) begin
            tests_failed++;
            $display("FAIL oob_l3 got v=%b oob=%b q=%h exp v=1 oob=1 q=%h", qv3, oob3, q3, NOP);
        end
        idle(2);
        write_word(12'h400, 32'hBAD);
        write_word(12'h3FF, 32'hCAFE);
        rd_en = 1'b1; address = 12'h000;
        step();
        address = 12'h3FF;
        step();
        tests_run++;
        if (qv2 !== 1'b1 || oob2 !== 1'b0 || q2 !== 32'h11) begin
            tests_failed++;
            $display("FAIL oob_alias_l2 got v=%b oob=%b q=%h exp v=1 oob=0 q=00000011", qv2, oob2, q2);
        end
        rd_en = 1'b0;
        step();
        tests_run++;
        if (qv2 !== 1'b1 || oob2 !== 1'b0 || q2 !== 32'hCAFE) begin
            tests_failed++;
            $display("FAIL last_word_l2 got v=%b oob=%b q=%h exp v=1 oob=0 q=0000cafe", qv2, oob2, q2);
        end
        idle(3);
    endtask

    task automatic test_reset_in_flight();
        rd_en = 1'b1; address = 12'd1;
        step();
        address = 12'd2;
        step();
        reset = 1'b1; address = 12'd3;
        step();
        tests_run++;
        if (qv3 !== 1'b0 || q3 !== NOP || oob3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_l3 got v=%b q=%h oob=%b exp v=0 q=%h oob=0", qv3, q3, oob3, NOP);
        end
        reset = 1'b0; rd_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            tests_run++;
            if (qv3 !== 1'b0 || qv2 !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_ghost c=%0d got v2=%b v3=%b exp 0 0", c, qv2, qv3);
            end
        end
        rd_en = 1'b1; address = 12'd2;
        step();
        rd_en = 1'b0;
        step();
        step();
        tests_run++;
        if (qv3 !== 1'b1 || q3 !== 32'h33) begin
            tests_failed++;
            $display("FAIL mem_kept_l3 got v=%b q=%h exp v=1 q=00000033", qv3, q3);
        end
        idle(3);
    endtask

    task automatic test_reset_over_stall();
        rd_en = 1'b1; address = 12'd0;
        step();
        address = 12'd1;
        step();
        reset = 1'b1; stall = 1'b1; address = 12'd2;
        step();
        tests_run++;
        if (qv2 !== 1'b0 || q2 !== NOP || qv3 !== 1'b0 || q3 !== NOP) begin
            tests_failed++;
            $display("FAIL rst_stall got v2=%b q2=%h v3=%b q3=%h exp v=0 q=%h", qv2, q2, qv3, q3, NOP);
        end
        reset = 1'b0; stall = 1'b0; rd_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            tests_run++;
            if (qv2 !== 1'b0 || qv3 !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_stall_ghost c=%0d got v2=%b v3=%b exp 0 0", c, qv2, qv3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_read_during_write();
        test_oob();
        test_reset_in_flight();
        test_reset_over_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/imem_pipelined.md
# imem_pipelined

Parametrised, loadable instruction memory for the processor fetch stage: synchronous read with a configurable read-latency pipeline, a fetch-side stall that freezes in-flight reads, and a separate write port used by the loader/testbench to program the store at run time. Out-of-range fetches return a NOP word and are flagged. Contents are not cleared by reset; only the read pipeline is.

## Interface
- DATA_WIDTH, 32: instruction word width.
- ADDR_WIDTH, 12: address width of both ports.
- DEPTH, 4096: number of words implemented; legal range 1..2**ADDR_WIDTH.
- READ_LATENCY, 1: cycles from accepted request to q_valid; legal range 1..4.
- NOP_WORD, 0: value returned for out-of-range fetches and driven on q during reset.

- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rd_en  in  1  fetch request; accepted when rd_en=1 and stall=0.
- address  in  ADDR_WIDTH  fetch word address.
- stall  in  1  freezes the read pipeline and outputs.
- q  out  DATA_WIDTH  fetched word, registered.
- q_valid  out  1  q holds the result of an accepted request.
- oob  out  1  result in q came from address >= DEPTH; meaningful only while q_valid=1.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.

## Operation
- Storage: DEPTH x DATA_WIDTH array; initialised to all-zero at time 0; never cleared by reset.
- Write: on a rising edge with wr_en=1 and wr_addr < DEPTH, mem[wr_addr] <= wr_data. wr_addr >= DEPTH: write dropped, no other effect. Writes are independent of stall and reset.
- Read pipeline: READ_LATENCY stages, each holding {valid, oob, data}.
  - Stage 1 captures on acceptance: valid=1, oob=(address >= DEPTH), data = oob ? NOP_WORD : mem[address].
  - Not accepted (rd_en=0, stall=0): stage 1 captures valid=0, oob=0, data unchanged.
  - Stages 2..L shift forward each unstalled cycle; q/q_valid/oob are stage L.
- Stall: while stall=1, every stage holds (including q, q_valid, oob); rd_en ignored; no request lost or duplicated. A q_valid=1 result held under stall counts once.
- Read-during-write, same address, same edge: read returns the OLD contents (read-first); the new word is visible to reads accepted on the following edge.
- Reset: all stage valid and oob bits cleared to 0, q = NOP_WORD; in-flight requests discarded; a request presented in the reset cycle is not accepted. Reset has priority over stall.

## Timing
- Reset values: q = NOP_WORD, q_valid = 0, oob = 0.
- Accepted request at edge E -> q/q_valid/oob valid after edge E+READ_LATENCY-1 (READ_LATENCY=1: visible just after E, i.e. registered-address equivalent).
- Each stall cycle adds exactly one cycle to the latency of every in-flight request.
- Throughput: one accepted request per unstalled cycle; back-to-back results appear on consecutive cycles in request order.
- q_valid pulses one cycle per request (unless held by stall); q keeps last data when q_valid=0 except after reset.
- Write-to-read: write at edge W is returned by a read accepted at edge W+1 or later.

## Test plan
- Load mem[0..3] = 0x11,0x22,0x33,0x44 (READ_LATENCY=2); fetch 0,1,2,3 back-to-back -> q_valid high 4 consecutive cycles starting 2 cycles after first request, q = 0x11,0x22,0x33,0x44, oob=0.
- Same stream with stall=1 for 3 cycles after second request -> q/q_valid frozen during stall, remaining results resume in order, no duplicates, total delay +3 cycles.
- wr_en=1, wr_addr=5, wr_data=0xDEAD with rd_en=1, address=5 same edge (old value 0) -> returned q=0; re-read next cycle -> q=0xDEAD.
- DEPTH=1024: fetch address 0x400 -> q=NOP_WORD, oob=1, q_valid=1; write to 0x400 then read 0x000 -> mem[0] unchanged.
- Reset asserted for 1 cycle while 2 requests in flight (READ_LATENCY=3) -> q_valid=0, q=NOP_WORD next cycle, discarded results never appear; mem contents intact on subsequent reads.
- Reset and stall both high -> pipeline cleared (reset wins); rd_en in reset cycle produces no q_valid.
